// File: rtl/fetch2.sv
// Second fetch stage: captures 64-bit imem pairs into a small FIFO for decode.
// The PC write-enable uses credits, so every in-flight response always has a free slot.
module fetch2 #(
    parameter int unsigned DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    input  logic [63:0] imem_data_i,
    input  logic        flush_i,
    input  logic        dec_ready_i,
    output logic        pc_we_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst0_o,
    output logic [31:0] inst1_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthC = DEPTH[CntW:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            push, pop;
    logic [CntW:0]   credits_used;
    entry_t          head;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        valid_o = ~reset_i & (count_q != '0);
        pop     = valid_o & dec_ready_i & ~flush_i;
        push    = inflight_q & ~flush_i & ~reset_i;
        // Slots already promised, minus the one freed by this cycle's pop.
        credits_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
        pc_we_o = ~reset_i & ~flush_i & (credits_used < DepthC);
        pc_o    = valid_o ? head.pc : 32'h0;
        inst0_o = valid_o ? head.inst0 : NOP;
        inst1_o = valid_o ? head.inst1 : NOP;
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d    = count_q + CntW'(push) - CntW'(pop);
            inflight_d = pc_we_o;
            if (pc_we_o) inflight_pc_d = pc_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Payload has no reset; valid_o masks any stale slot.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: inflight_pc_q, inst0: imem_data_i[31:0],
                                 inst1: imem_data_i[63:32]};
        end
    end

endmodule
